// File: rtl/adc_emu_pkg.sv
// ---------------------------------------------------------------------------
// adc_emu_pkg
// Shared constants and types for the ADC SPI responder (ADC emulator).
//   - Frame geometry: 16-bit frame = 4 leading zeros + 12-bit sample.
//   - Address bits ADD2..ADD0 arrive on SCLK rising edges 3..5.
//   - FSM state encoding and channel index constants.
//   - addr_from_din: pulls the channel address out of the captured DIN word.
// ---------------------------------------------------------------------------
package adc_emu_pkg;

  localparam int FRAME_BITS      = 16;
  localparam int LEAD_ZEROS      = 4;
  localparam int SAMPLE_W        = 12;
  localparam int ADDR_FIRST_EDGE = 3;
  localparam int ADDR_LAST_EDGE  = 5;

  // Bit count must be able to hold FRAME_BITS itself.
  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  // After a full frame the bit captured on edge k sits at din_sr[FRAME_BITS-k].
  localparam int ADDR_MSB = FRAME_BITS - ADDR_FIRST_EDGE;
  localparam int ADDR_LSB = FRAME_BITS - ADDR_LAST_EDGE;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic [2:0] CH_RAMP   = 3'd0;
  localparam logic [2:0] CH_TRI    = 3'd1;
  localparam logic [2:0] CH_SQUARE = 3'd2;
  localparam logic [2:0] CH_MID    = 3'd3;
  localparam logic [2:0] CH_CONST4 = 3'd4;
  localparam logic [2:0] CH_CONST5 = 3'd5;
  localparam logic [2:0] CH_CONST6 = 3'd6;
  localparam logic [2:0] CH_EXT    = 3'd7;

  function automatic logic [2:0] addr_from_din(input logic [FRAME_BITS-1:0] sr);
    return sr[ADDR_MSB:ADDR_LSB];
  endfunction

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Two-flop synchroniser for an asynchronous pin plus single-cycle edge pulses.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset (all flops clear to 0)
//   d_i     : asynchronous input pin
//   level_o : synchronised level
//   rise_o  : one-cycle pulse on a synchronised 0->1 transition
//   fall_o  : one-cycle pulse on a synchronised 1->0 transition
// Pin edge to pulse being acted on by a downstream register: 3 clk cycles.
// ---------------------------------------------------------------------------
module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       dly_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      dly_q  <= sync_q[1];
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~dly_q;
  assign fall_o  = ~sync_q[1] & dly_q;

endmodule

// File: rtl/adc_spi_responder.sv
// ---------------------------------------------------------------------------
// adc_spi_responder
// Emulates an 8-channel 12-bit serial ADC as SPI responder in the CLOCK_50
// domain, feeding deterministic waveforms to the existing ADC SPI master.
// Ports:
//   CLOCK_50    : 50 MHz system clock
//   RESET_N     : asynchronous active-low reset
//   ADC_CS_N    : frame select from master (active-low)
//   ADC_SCLK    : serial clock from master (high/low >= 4 CLOCK_50 cycles)
//   ADC_DIN     : serial address/config bits from master
//   ADC_DOUT    : serial sample data to master (MSB first, 4 leading zeros)
//   ext_sample  : sample returned for channel 7
//   cur_channel : channel the next frame will return
//   frame_done  : one-cycle pulse when a complete frame ends
//   frame_err   : one-cycle pulse when CS_N rises before the 16th SCLK rise
// Channels: 0 ramp, 1 triangle, 2 square, 3 mid-scale, 4..6 constants,
// 7 ext_sample.
// ---------------------------------------------------------------------------
module adc_spi_responder
  import adc_emu_pkg::*;
#(
  parameter int                  TICK_DIV   = 64,
  parameter int                  PHASE_STEP = 1,
  parameter logic [SAMPLE_W-1:0] CONST4     = 12'h000,
  parameter logic [SAMPLE_W-1:0] CONST5     = 12'hFFF,
  parameter logic [SAMPLE_W-1:0] CONST6     = 12'h555
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                ADC_CS_N,
  input  logic                ADC_SCLK,
  input  logic                ADC_DIN,
  output logic                ADC_DOUT,
  input  logic [SAMPLE_W-1:0] ext_sample,
  output logic [2:0]          cur_channel,
  output logic                frame_done,
  output logic                frame_err
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic cs_rise, cs_fall, cs_lvl_unused;
  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic din_lvl, din_rise_unused, din_fall_unused;

  sync_edge u_sync_cs (
    .clk_i  (CLOCK_50),
    .rst_ni (RESET_N),
    .d_i    (ADC_CS_N),
    .level_o(cs_lvl_unused),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  sync_edge u_sync_sclk (
    .clk_i  (CLOCK_50),
    .rst_ni (RESET_N),
    .d_i    (ADC_SCLK),
    .level_o(sclk_lvl_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge u_sync_din (
    .clk_i  (CLOCK_50),
    .rst_ni (RESET_N),
    .d_i    (ADC_DIN),
    .level_o(din_lvl),
    .rise_o (din_rise_unused),
    .fall_o (din_fall_unused)
  );

  // Waveform phase generator
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [SAMPLE_W-1:0] phase_q, phase_d;

  always_comb begin
    tick_d  = tick_q + TICK_W'(1);
    phase_d = phase_q;
    if (tick_q == TICK_W'(TICK_DIV - 1)) begin
      tick_d  = '0;
      phase_d = phase_q + SAMPLE_W'(PHASE_STEP);
    end
  end

  // Sample for the currently selected channel
  logic [SAMPLE_W-1:0] sample;
  logic [2:0]          cur_ch_q, cur_ch_d;

  always_comb begin
    sample = '0;
    case (cur_ch_q)
      CH_RAMP:   sample = phase_q;
      CH_TRI:    sample = phase_q[11] ? {~phase_q[10:0], 1'b0} : {phase_q[10:0], 1'b0};
      CH_SQUARE: sample = phase_q[11] ? 12'hFFF : 12'h000;
      CH_MID:    sample = 12'h800;
      CH_CONST4: sample = CONST4;
      CH_CONST5: sample = CONST5;
      CH_CONST6: sample = CONST6;
      CH_EXT:    sample = ext_sample;
      default:   sample = '0;
    endcase
  end

  // Frame FSM
  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] din_sr_q, din_sr_d;
  logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    din_sr_d = din_sr_q;
    bitcnt_d = bitcnt_q;
    cur_ch_d = cur_ch_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          // Snapshot freezes the sample for the whole frame.
          shift_d  = {{LEAD_ZEROS{1'b0}}, sample};
          din_sr_d = '0;
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          din_sr_d = {din_sr_q[FRAME_BITS-2:0], din_lvl};
          bitcnt_d = bitcnt_q + CNT_W'(1);
        end
        // No shift before the first rising edge so bit 15 is read on edge 1.
        if (sclk_fall && (bitcnt_q != '0)) begin
          shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
        end
        // SCLK edge is applied first; a coincident CS_N rise then sees the
        // updated bit count and the final DIN bit.
        if (bitcnt_d == CNT_W'(FRAME_BITS)) begin
          state_d = DONE;
          if (cs_rise) begin
            cur_ch_d = addr_from_din(din_sr_d);
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        end else if (cs_rise) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        if (cs_rise) begin
          cur_ch_d = addr_from_din(din_sr_q);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_q   <= '0;
      phase_q  <= '0;
      state_q  <= IDLE;
      shift_q  <= '0;
      din_sr_q <= '0;
      bitcnt_q <= '0;
      cur_ch_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      phase_q  <= phase_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      din_sr_q <= din_sr_d;
      bitcnt_q <= bitcnt_d;
      cur_ch_q <= cur_ch_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ADC_DOUT    = (state_q == SHIFT) & shift_q[FRAME_BITS-1];
  assign cur_channel = cur_ch_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_responder
// Directed bench for adc_spi_responder with TICK_DIV=4, PHASE_STEP=1.
// The ramp value captured at a CS_N fall driven when 'cyc' clock edges have
// elapsed since reset release is floor((cyc+2)/4): the sample is latched on
// the third edge after the pin change, holding the phase from edge cyc+2.
// ---------------------------------------------------------------------------
module tb_adc_spi_responder;

  logic        CLOCK_50;
  logic        RESET_N;
  logic        ADC_CS_N;
  logic        ADC_SCLK;
  logic        ADC_DIN;
  logic        ADC_DOUT;
  logic [11:0] ext_sample;
  logic [2:0]  cur_channel;
  logic        frame_done;
  logic        frame_err;

  adc_spi_responder #(
    .TICK_DIV  (4),
    .PHASE_STEP(1),
    .CONST4    (12'h000),
    .CONST5    (12'hFFF),
    .CONST6    (12'h555)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .ADC_CS_N   (ADC_CS_N),
    .ADC_SCLK   (ADC_SCLK),
    .ADC_DIN    (ADC_DIN),
    .ADC_DOUT   (ADC_DOUT),
    .ext_sample (ext_sample),
    .cur_channel(cur_channel),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  always @(posedge CLOCK_50) begin
    if (!RESET_N) cyc <= 0;
    else          cyc <= cyc + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_err)  err_cnt  <= err_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  function automatic logic [11:0] ramp_at(input int c0);
    return 12'((c0 + 2) / 4);
  endfunction

  // One SCLK period: DIN set, low time, sample DOUT as the master would at
  // the rising edge, high time, SCLK back low.
  task automatic sclk_cycle(input logic din, output logic dout);
    ADC_DIN = din;
    wait_clk(5);
    dout = ADC_DOUT;
    ADC_SCLK = 1'b1;
    wait_clk(5);
    ADC_SCLK = 1'b0;
  endtask

  // Full master transaction. Address bits go out on edges 3..5 (MSB first),
  // every other edge carries 'fill'. Returns with CS_N just raised.
  task automatic xfer(input logic [2:0] addr, input int nedges, input logic fill,
                      output logic [15:0] rx, output int tail_ones, output int c0);
    logic b;
    logic d;
    rx        = '0;
    tail_ones = 0;
    ADC_CS_N  = 1'b0;
    c0        = cyc;
    wait_clk(6);
    for (int k = 1; k <= nedges; k++) begin
      d = (k >= 3 && k <= 5) ? addr[5-k] : fill;
      sclk_cycle(d, b);
      if (k <= 16) rx[16-k] = b;
      else         tail_ones += int'(b);
    end
    wait_clk(5);
    ADC_CS_N = 1'b1;
  endtask

  logic [15:0] rx;
  logic [11:0] ph;
  logic        bit_s;
  int          tail, c0, d0, e0;

  initial begin
    RESET_N    = 1'b0;
    ADC_CS_N   = 1'b1;
    ADC_SCLK   = 1'b0;
    ADC_DIN    = 1'b0;
    ext_sample = 12'h000;
    wait_clk(5);
    check_eq("rst_dout", 32'(ADC_DOUT), 32'd0);
    check_eq("rst_chan", 32'(cur_channel), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    check_eq("rst_err",  32'(frame_err), 32'd0);
    RESET_N = 1'b1;

    // 1: ramp snapshot after 100 cycles
    wait_clk(100);
    d0 = done_cnt;
    xfer(3'b000, 16, 1'b0, rx, tail, c0);
    wait_clk(6);
    check_eq("t1_ramp", 32'(rx), 32'h0019);
    check_eq("t1_ramp_formula", 32'(rx), 32'({4'h0, ramp_at(c0)}));
    check_eq("t1_done", 32'(done_cnt - d0), 32'd1);
    check_eq("t1_chan", 32'(cur_channel), 32'd0);

    // 2: select square, then read it with phase[11] set
    xfer(3'b010, 16, 1'b0, rx, tail, c0);
    wait_clk(6);
    check_eq("t2_ramp", 32'(rx), 32'({4'h0, ramp_at(c0)}));
    check_eq("t2_chan", 32'(cur_channel), 32'd2);
    wait_clk(8200);
    xfer(3'b000, 16, 1'b0, rx, tail, c0);
    wait_clk(6);
    ph = ramp_at(c0);
    check_eq("t2_sq_hi", 32'(ph[11]), 32'd1);
    check_eq("t2_square", 32'(rx), ph[11] ? 32'h0FFF : 32'h0000);

    // 3: external sample, changed mid-frame
    ext_sample = 12'hA5C;
    xfer(3'b111, 16, 1'b0, rx, tail, c0);
    wait_clk(6);
    check_eq("t3_chan7", 32'(cur_channel), 32'd7);
    fork
      xfer(3'b000, 16, 1'b0, rx, tail, c0);
      begin
        wait_clk(60);
        ext_sample = 12'h3C3;
      end
    join
    wait_clk(6);
    check_eq("t3_ext", 32'(rx), 32'h0A5C);
    check_eq("t3_chan0", 32'(cur_channel), 32'd0);

    // 4: abort after 9 edges
    xfer(3'b010, 16, 1'b0, rx, tail, c0);
    wait_clk(6);
    check_eq("t4_chan2", 32'(cur_channel), 32'd2);
    d0 = done_cnt;
    e0 = err_cnt;
    xfer(3'b101, 9, 1'b0, rx, tail, c0);
    check_eq("t4_bits", 32'(rx[15:7]), 32'(9'b0000_11111));
    wait_clk(4);
    check_eq("t4_dout_idle", 32'(ADC_DOUT), 32'd0);
    wait_clk(6);
    check_eq("t4_err", 32'(err_cnt - e0), 32'd1);
    check_eq("t4_done", 32'(done_cnt - d0), 32'd0);
    check_eq("t4_chan", 32'(cur_channel), 32'd2);

    // 5: 20 SCLK cycles, DIN=1 outside the address window
    d0 = done_cnt;
    xfer(3'b110, 20, 1'b1, rx, tail, c0);
    wait_clk(6);
    ph = ramp_at(c0);
    check_eq("t5_square", 32'(rx), ph[11] ? 32'h0FFF : 32'h0000);
    check_eq("t5_tail", 32'(tail), 32'd0);
    check_eq("t5_done", 32'(done_cnt - d0), 32'd1);
    check_eq("t5_chan", 32'(cur_channel), 32'd6);
    xfer(3'b011, 16, 1'b0, rx, tail, c0);
    wait_clk(6);
    check_eq("t5_const6", 32'(rx), 32'h0555);

    // 6: reset in the middle of a channel-3 frame
    check_eq("t6_chan3", 32'(cur_channel), 32'd3);
    rx = '0;
    ADC_CS_N = 1'b0;
    wait_clk(6);
    for (int k = 1; k <= 8; k++) begin
      sclk_cycle(1'b0, bit_s);
      rx[16-k] = bit_s;
    end
    check_eq("t6_byte", 32'(rx[15:8]), 32'h08);
    wait_clk(2);
    RESET_N = 1'b0;
    #1;
    check_eq("t6_rst_dout", 32'(ADC_DOUT), 32'd0);
    check_eq("t6_rst_chan", 32'(cur_channel), 32'd0);
    wait_clk(4);
    RESET_N = 1'b1;
    wait_clk(4);
    ADC_CS_N = 1'b1;
    wait_clk(10);
    d0 = done_cnt;
    xfer(3'b000, 16, 1'b0, rx, tail, c0);
    wait_clk(6);
    check_eq("t6_ramp", 32'(rx), 32'({4'h0, ramp_at(c0)}));
    check_eq("t6_done", 32'(done_cnt - d0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
